// File: rtl/divrip_seq.sv
// divrip_seq: 4-bit unsigned restoring divider, one quotient bit per cycle
module divrip_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic [4:0] r_sh, t;
  // next state: operand capture, one restoring step per RUN cycle, results latched on DONE entry
  always_comb begin
    state_d = state_q;
    dvs_d = dvs_q;
    r_d = r_q;
    q_d = q_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    r_sh = {r_q[3:0], q_q[3]};
    t = r_sh - {1'b0, dvs_q};
    case (state_q)
      IDLE: if (start) begin
        dvs_d = divisor;
        r_d = '0;
        q_d = dividend;
        cnt_d = '0;
        state_d = (divisor == 4'd0) ? DONE : RUN;
        if (divisor == 4'd0) begin
          quo_d = 4'hF;
          rem_d = dividend;
          dbz_d = 1'b1;
        end
      end
      RUN: begin
        r_d = t[4] ? r_sh : t;
        q_d = {q_q[2:0], ~t[4]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          quo_d = {q_q[2:0], ~t[4]};
          rem_d = t[4] ? r_sh[3:0] : t[3:0];
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvs_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvs_q <= dvs_d;
      r_q <= r_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divrip_seq.sv
// tb_divrip_seq: directed and exhaustive checks of the sequential divider
module tb_divrip_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int checks = 0;
  int errors = 0;
  int lat, bc, dc;
  logic qchg;

  divrip_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge in IDLE; returns at the negedge of the done cycle
  // lat = k means done seen in the cycle following start edge + k
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit hold,
                         output int l, output int bcnt, output logic chg);
    logic [3:0] q0;
    q0 = quotient;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      dividend = 4'd7;
      divisor = 4'd7;
    end else begin
      start = 1'b0;
      dividend = ~a;
      divisor = ~b;
    end
    l = -1;
    bcnt = 0;
    chg = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bcnt += int'(busy);
      if (done) begin
        l = k;
        break;
      end
      if (quotient !== q0) chg = 1'b1;
    end
  endtask

  task automatic finish_div(input string tag);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    run_div(4'd13, 4'd3, 0, lat, bc, qchg);
    check("d13_3_lat", lat, 4);
    check("d13_3_quo", quotient, 4);
    check("d13_3_rem", remainder, 1);
    check("d13_3_dbz", div_by_zero, 0);
    check("d13_3_busy", bc, 5);
    check("d13_3_hold", qchg, 0);
    finish_div("d13_3");

    run_div(4'd15, 4'd1, 0, lat, bc, qchg);
    check("d15_1_quo", quotient, 15);
    check("d15_1_rem", remainder, 0);
    finish_div("d15_1");
    run_div(4'd3, 4'd5, 0, lat, bc, qchg);
    check("d3_5_quo", quotient, 0);
    check("d3_5_rem", remainder, 3);
    check("d3_5_hold", qchg, 0);
    finish_div("d3_5");

    run_div(4'd9, 4'd0, 0, lat, bc, qchg);
    check("d9_0_lat", lat, 0);
    check("d9_0_quo", quotient, 15);
    check("d9_0_rem", remainder, 9);
    check("d9_0_dbz", div_by_zero, 1);
    check("d9_0_busy", bc, 1);
    finish_div("d9_0");

    run_div(4'd12, 4'd4, 1, lat, bc, qchg);
    check("d12_4_lat", lat, 4);
    check("d12_4_quo", quotient, 3);
    check("d12_4_rem", remainder, 0);
    check("d12_4_dbz", div_by_zero, 0);
    start = 1'b0;
    dc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dc += int'(done);
    end
    check("d12_4_no_second_done", dc, 0);

    dividend = 4'd14;
    divisor = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quo", quotient, 0);
    check("abort_rem", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    dc = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dc += int'(done);
    end
    check("abort_no_done", dc, 0);
    run_div(4'd14, 4'd5, 0, lat, bc, qchg);
    check("d14_5_lat", lat, 4);
    check("d14_5_quo", quotient, 2);
    check("d14_5_rem", remainder, 4);
    finish_div("d14_5");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), 0, lat, bc, qchg);
        check($sformatf("sw_%0d_%0d_lat", a, b), lat, (b == 0) ? 0 : 4);
        check($sformatf("sw_%0d_%0d_quo", a, b), quotient, (b == 0) ? 15 : a / b);
        check($sformatf("sw_%0d_%0d_rem", a, b), remainder, (b == 0) ? a : a % b);
        check($sformatf("sw_%0d_%0d_dbz", a, b), div_by_zero, (b == 0) ? 1 : 0);
        finish_div($sformatf("sw_%0d_%0d", a, b));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
